br_arb_multi_rr: RTL and testbench
==================================

// Module: br_arb_multi_rr
// PURPOSE
// - Multi-grant round-robin arbiter: up to NumGrants of NumRequesters requests granted per cycle.
// - Grants go in rotating priority order. The priority pointer is stateful and advances past the last grantee.
// - Built on the dynamic priority encoder: the pointer register drives its lowest_prio input.
// - Sits in front of multi-ported resources (banks, multi-issue pipes, wide crossbars).
// PARAMETERS
// - NumRequesters  2  number of requesters; must be >= 2
// - NumGrants      1  max grants per cycle; 1 <= NumGrants <= NumRequesters
// - CountWidth     $clog2(NumGrants+1)  width of grant_count (derived localparam, not overridable)
// PORTS
// - clk                     input   1                        clock
// - rst                     input   1                        synchronous, active-high reset
// - enable_priority_update  input   1                        1: pointer advances on cycles with >=1 grant
// - request                 input   NumRequesters            per-requester request
// - grant                   output  NumRequesters            OR of all grant slots
// - grant_ordered           output  NumGrants x NumRequesters slot k one-hot = k-th grantee in priority order
// - grant_count             output  CountWidth               number of bits set in grant
// - grant_limit             input   CountWidth               present only with the macro (see CONFIGURATION)
// BEHAVIOUR
// - State: lowest_prio_q, one-hot NumRequesters. Reset value 1<<(NumRequesters-1), so requester 0 has highest priority.
// - Priority order: start at (index(lowest_prio_q)+1) mod NumRequesters, ascend, wrap; lowest_prio_q's requester is last.
// - Grants: the first min(NumGrants, popcount(request)) set requests in priority order.
//   - Slot k holds the k-th of these. Unused slots are 0.
// - Latency: grant outputs are combinational from request and lowest_prio_q (0 cycles). No output registers.
// - Reset: while rst=1, grant, grant_ordered and grant_count are forced to 0, whatever request is.
// - Pointer update at posedge: if !rst && enable_priority_update && grant!=0,
//   - lowest_prio_q <= highest-numbered non-zero slot of grant_ordered (the last grantee).
//   - Otherwise lowest_prio_q holds.
// - request==0: all outputs 0 and the pointer holds, even with enable_priority_update=1.
// - enable_priority_update=0: grants are still produced. Repeated cycles with the same request give identical grants.
// - Reset mid-operation: pointer returns to its reset value on the next edge. No partial state survives.
// - Fairness: with all requests held and enable_priority_update=1, each requester is granted at least once every
//   ceil(NumRequesters/NumGrants) cycles.
// - Assertions:
//   - lowest_prio_q is always one-hot.
//   - grant is a subset of request.
//   - grant_ordered slots are mutually exclusive.
//   - grant_count <= NumGrants.
//   - Parameter legality is checked at elaboration.
// CONFIGURATION
// - Macro BR_ARB_MULTI_RR_GRANT_LIMIT_EN.
// - Defined:
//   - Adds the grant_limit input.
//   - Grants per cycle = min(NumGrants, grant_limit, popcount(request)). Slots beyond the limit are 0.
//   - grant_limit==0: no grants, and the pointer holds.
//   - grant_limit>NumGrants behaves as NumGrants.
//   - The pointer still advances to the last actual grantee.
// - Undefined: grant_limit port absent. Behaviour equals the defined case with grant_limit tied to NumGrants.
// TESTING (NumRequesters=8, NumGrants=3 unless stated)
// - Post-reset, request=8'hFF, enable_priority_update=0 for 4 cycles
//   -> every cycle grant=8'h07, grant_ordered={8'h04,8'h02,8'h01}, grant_count=3.
// - request=8'hFF, enable_priority_update=1 for 3 cycles -> grant 8'h07, 8'h38, 8'hC1.
//   - 3rd-cycle grant_ordered={8'h01,8'h80,8'h40} (wrap-around).
// - Post-reset, request=8'h81, enable_priority_update=1 -> grant=8'h81, grant_ordered={0,8'h80,8'h01}.
//   - Pointer lands on 7. Next cycle, same request: identical grants.
// - request=8'h00 with enable_priority_update=1 for 2 cycles, then request=8'hFF -> zeros, then grant=8'h07.
//   - Confirms the pointer held.
// - Advance the pointer to 5, assert rst for 1 cycle with request=8'hFF
//   -> grant=0 during reset; first cycle after, grant=8'h07.
// - Exhaustive: all 8 pointer positions x all 256 request values vs a behavioural model;
//   also repeated with NumGrants=1 and NumGrants=8.
// - Macro defined, grant_limit=1, request=8'hFF, enable_priority_update=1
//   -> grant 8'h01, 8'h02, 8'h04, grant_count=1.
//   - Then grant_limit=0 -> grant=0 and the pointer holds.

Source files
------------

// File: rtl/br_arb_multi_rr.sv
// -----------------------------------------------------------------------------
// br_arb_multi_rr
// Multi-grant round-robin arbiter. Each cycle, up to NumGrants of the
// NumRequesters requests are granted in rotating priority order. A one-hot
// pointer register marks the lowest-priority requester. This register is the
// "lowest_prio" input of a dynamic priority encoder. The pointer moves to
// the last grantee, so that requester gets the lowest priority next time.
//
// Parameters
//   NumRequesters  number of requesters (>= 2)
//   NumGrants      maximum grants per cycle (1..NumRequesters)
//   CountWidth     width of grant_count, derived, not overridable
//
// Ports
//   clk                     clock
//   rst                     synchronous, active-high reset
//   enable_priority_update  1: pointer advances on cycles with >= 1 grant
//   request                 per-requester request
//   grant                   OR of all grant slots
//   grant_ordered           slot k one-hot = k-th grantee in priority order
//   grant_count             number of bits set in grant
//   grant_limit             runtime cap on grants per cycle (only when
//                           BR_ARB_MULTI_RR_GRANT_LIMIT_EN is defined)
//
// Grant outputs are purely combinational from request and the pointer.
// They are forced to zero while rst is high.
// -----------------------------------------------------------------------------
module br_arb_multi_rr #(
  parameter  int NumRequesters = 2,
  parameter  int NumGrants     = 1,
  localparam int CountWidth    = $clog2(NumGrants + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable_priority_update,
  input  logic [NumRequesters-1:0]                 request,
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
  input  logic [CountWidth-1:0]                    grant_limit,
`endif
  output logic [NumRequesters-1:0]                 grant,
  output logic [NumGrants-1:0][NumRequesters-1:0]  grant_ordered,
  output logic [CountWidth-1:0]                    grant_count
);

  localparam int IdxWidth = $clog2(NumRequesters);

  if (NumRequesters < 2) begin : g_bad_requesters
    $error("br_arb_multi_rr: NumRequesters must be >= 2");
  end
  if (NumGrants < 1 || NumGrants > NumRequesters) begin : g_bad_grants
    $error("br_arb_multi_rr: NumGrants must be in 1..NumRequesters");
  end

  logic [NumRequesters-1:0] lowest_prio_q;
  logic [NumRequesters-1:0] lowest_prio_d;
  logic [IdxWidth-1:0]      ptr_idx;
  logic [IdxWidth-1:0]      pos_idx;
  logic [IdxWidth-1:0]      last_idx;
  int                       limit_eff;
  int                       used;

  // Binary index of the one-hot pointer.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (lowest_prio_q[i]) ptr_idx = IdxWidth'(i);
    end
  end

  // Number of grants allowed this cycle, before looking at requests.
  always_comb begin
    limit_eff = NumGrants;
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    if (int'(grant_limit) < NumGrants) limit_eff = int'(grant_limit);
`endif
  end

  // Dynamic priority encoder. The scan starts just after the pointer and
  // wraps around. The first limit_eff requesters found fill the slots in order.
  always_comb begin
    // NOTE: every output of this block gets a default before the scan. Any
    // path that leaves a variable unassigned would infer a latch.
    grant         = '0;
    grant_ordered = '0;
    grant_count   = '0;
    last_idx      = ptr_idx;
    pos_idx       = '0;
    used          = 0;
    for (int step = 1; step <= NumRequesters; step++) begin
      pos_idx = IdxWidth'((int'(ptr_idx) + step) % NumRequesters);
      if (request[pos_idx] && used < limit_eff) begin
        for (int k = 0; k < NumGrants; k++) begin
          if (k == used) grant_ordered[k][pos_idx] = 1'b1;
        end
        grant[pos_idx] = 1'b1;
        last_idx       = pos_idx;
        used++;
      end
    end
    grant_count = CountWidth'(used);
    if (rst) begin
      grant         = '0;
      grant_ordered = '0;
      grant_count   = '0;
    end
  end

  // The last grantee becomes the lowest-priority requester.
  assign lowest_prio_d = NumRequesters'(1) << last_idx;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every register then
    // samples pre-edge values, independent of process ordering.
    if (rst) begin
      lowest_prio_q <= NumRequesters'(1) << (NumRequesters - 1);
    end else if (enable_priority_update && (grant != '0)) begin
      lowest_prio_q <= lowest_prio_d;
    end
  end

  function automatic int slot_bits(
    input logic [NumGrants-1:0][NumRequesters-1:0] slots
  );
    int total = 0;
    for (int k = 0; k < NumGrants; k++) total += $countones(slots[k]);
    return total;
  endfunction

  a_ptr_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(lowest_prio_q));
  a_grant_subset: assert property (@(posedge clk)
    (grant & ~request) == '0);
  a_slots_exclusive: assert property (@(posedge clk)
    slot_bits(grant_ordered) == $countones(grant));
  a_count_bound: assert property (@(posedge clk)
    int'(grant_count) <= NumGrants);

endmodule

// File: tb/tb_br_arb_multi_rr.sv
// -----------------------------------------------------------------------------
// tb_br_arb_multi_rr
// This bench runs three instances of br_arb_multi_rr side by side, all with
// 8 requesters. They use NumGrants of 3, 1 and 8 and share one request stream.
// A queue-based reference model follows each instance's pointer. A single
// negedge process compares all outputs of all instances every cycle.
// Directed sequences also pin the NumGrants=3 instance to hand-computed
// literals.
// -----------------------------------------------------------------------------
module tb_br_arb_multi_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] request = 8'h00;

  always #5 clk = ~clk;

  logic [7:0]      g3, g1, g8;
  logic [2:0][7:0] go3;
  logic [0:0][7:0] go1;
  logic [7:0][7:0] go8;
  logic [1:0]      c3;
  logic [0:0]      c1;
  logic [3:0]      c8;

`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
  logic [1:0] lim3 = 2'd3;
  logic [0:0] lim1 = 1'b1;
  logic [3:0] lim8 = 4'd15;
`endif

  br_arb_multi_rr #(.NumRequesters(8), .NumGrants(3)) u_ng3 (
    .clk(clk), .rst(rst), .enable_priority_update(en), .request(request),
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    .grant_limit(lim3),
`endif
    .grant(g3), .grant_ordered(go3), .grant_count(c3));

  br_arb_multi_rr #(.NumRequesters(8), .NumGrants(1)) u_ng1 (
    .clk(clk), .rst(rst), .enable_priority_update(en), .request(request),
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    .grant_limit(lim1),
`endif
    .grant(g1), .grant_ordered(go1), .grant_count(c1));

  br_arb_multi_rr #(.NumRequesters(8), .NumGrants(8)) u_ng8 (
    .clk(clk), .rst(rst), .enable_priority_update(en), .request(request),
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    .grant_limit(lim8),
`endif
    .grant(g8), .grant_ordered(go8), .grant_count(c8));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mptr [3] = '{7, 7, 7};

  function automatic int num_grants(input int inst);
    return (inst == 0) ? 3 : (inst == 1) ? 1 : 8;
  endfunction

  function automatic int max_grants(input int inst);
    int m = num_grants(inst);
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    int lim = (inst == 0) ? int'(lim3) : (inst == 1) ? int'(lim1) : int'(lim8);
    if (lim < m) m = lim;
`endif
    return m;
  endfunction

  // The priority list runs from pointer+1 upward and wraps. Filter it to the
  // requesting indices, then keep the first max_grants of them.
  function automatic void model(input int inst, output logic [7:0] g,
                                output logic [63:0] ord, output int cnt,
                                output int last);
    int order[$];
    int picked[$];
    g    = '0;
    ord  = '0;
    cnt  = 0;
    last = mptr[inst];
    if (rst) return;
    for (int s = 1; s <= 8; s++) order.push_back((mptr[inst] + s) % 8);
    foreach (order[i]) begin
      if (((request >> order[i]) & 8'h01) != 8'h00 &&
          picked.size() < max_grants(inst))
        picked.push_back(order[i]);
    end
    foreach (picked[k]) begin
      ord = ord | (64'(1) << (k * 8 + picked[k]));
      g   = g | (8'(1) << picked[k]);
    end
    cnt = picked.size();
    if (cnt > 0) last = picked[cnt-1];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0]  mg;
      logic [63:0] mo;
      int          mc, ml;
      model(i, mg, mo, mc, ml);
      if (rst) mptr[i] = 7;
      else if (en && mc > 0) mptr[i] = ml;
    end
  end

  function automatic logic [7:0] dut_grant(input int inst);
    return (inst == 0) ? g3 : (inst == 1) ? g1 : g8;
  endfunction

  function automatic logic [63:0] dut_ord(input int inst);
    return (inst == 0) ? {40'b0, go3} : (inst == 1) ? {56'b0, go1} : go8;
  endfunction

  function automatic logic [63:0] dut_cnt(input int inst);
    return (inst == 0) ? 64'(c3) : (inst == 1) ? 64'(c1) : 64'(c8);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0]  mg;
      logic [63:0] mo;
      int          mc, ml;
      model(i, mg, mo, mc, ml);
      check($sformatf("model_ng%0d_grant", num_grants(i)),
            64'(dut_grant(i)), 64'(mg));
      check($sformatf("model_ng%0d_ordered", num_grants(i)), dut_ord(i), mo);
      check($sformatf("model_ng%0d_count", num_grants(i)), dut_cnt(i),
            64'(mc));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after posedge. The task returns just after
  // the following negedge, so outputs can be checked there.
  task automatic step(input logic [7:0] req, input logic e, input logic r,
                      input int lim = 15);
    @(posedge clk);
    #1;
    request = req;
    en      = e;
    rst     = r;
`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    lim3 = 2'((lim > 3) ? 3 : lim);
    lim1 = 1'(lim > 0);
    lim8 = 4'(lim);
`else
    if (lim < 0) $display("negative limit ignored");
`endif
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step(8'hFF, 1'b0, 1'b1);
    check("rst_grant", 64'(g3), 64'h0);
    check("rst_ordered", 64'(go3), 64'h0);
    check("rst_count", 64'(c3), 64'h0);

    for (int c = 0; c < 4; c++) begin
      step(8'hFF, 1'b0, 1'b0);
      check("hold_grant", 64'(g3), 64'h07);
      check("hold_ordered", 64'(go3), 64'h040201);
      check("hold_count", 64'(c3), 64'd3);
    end

    step(8'hFF, 1'b1, 1'b0);
    check("rot1_grant", 64'(g3), 64'h07);
    step(8'hFF, 1'b1, 1'b0);
    check("rot2_grant", 64'(g3), 64'h38);
    step(8'hFF, 1'b1, 1'b0);
    check("rot3_grant", 64'(g3), 64'hC1);
    check("rot3_ordered", 64'(go3), 64'h018040);

    step(8'h00, 1'b0, 1'b1);
    step(8'h81, 1'b1, 1'b0);
    check("r81_grant", 64'(g3), 64'h81);
    check("r81_ordered", 64'(go3), 64'h008001);
    check("r81_count", 64'(c3), 64'd2);
    step(8'h81, 1'b1, 1'b0);
    check("r81_again_grant", 64'(g3), 64'h81);
    check("r81_again_ordered", 64'(go3), 64'h008001);

    step(8'h00, 1'b1, 1'b0);
    check("idle1_grant", 64'(g3), 64'h0);
    check("idle1_count", 64'(c3), 64'h0);
    step(8'h00, 1'b1, 1'b0);
    check("idle2_grant", 64'(g3), 64'h0);
    step(8'hFF, 1'b0, 1'b0);
    check("after_idle_grant", 64'(g3), 64'h07);

    step(8'hFF, 1'b1, 1'b0);
    check("adv1_grant", 64'(g3), 64'h07);
    step(8'hFF, 1'b1, 1'b0);
    check("adv2_grant", 64'(g3), 64'h38);
    step(8'hFF, 1'b0, 1'b1);
    check("midrst_grant", 64'(g3), 64'h0);
    step(8'hFF, 1'b0, 1'b0);
    check("post_midrst_grant", 64'(g3), 64'h07);

`ifdef BR_ARB_MULTI_RR_GRANT_LIMIT_EN
    step(8'h00, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b0, 1);
    check("lim1_a_grant", 64'(g3), 64'h01);
    check("lim1_a_count", 64'(c3), 64'd1);
    step(8'hFF, 1'b1, 1'b0, 1);
    check("lim1_b_grant", 64'(g3), 64'h02);
    step(8'hFF, 1'b1, 1'b0, 1);
    check("lim1_c_grant", 64'(g3), 64'h04);
    check("lim1_c_count", 64'(c3), 64'd1);
    step(8'hFF, 1'b1, 1'b0, 0);
    check("lim0_a_grant", 64'(g3), 64'h0);
    check("lim0_a_count", 64'(c3), 64'h0);
    step(8'hFF, 1'b1, 1'b0, 0);
    check("lim0_b_grant", 64'(g3), 64'h0);
    step(8'hFF, 1'b0, 1'b0, 1);
    check("lim0_held_grant", 64'(g3), 64'h08);
`endif

    // Sweep: place the pointer on p with a single request, then freeze it
    // and apply every request pattern.
    for (int p = 0; p < 8; p++) begin
      step(8'h00, 1'b0, 1'b1);
      step(8'(1) << p, 1'b1, 1'b0);
      for (int r = 0; r < 256; r++) step(8'(r), 1'b0, 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
